// File: rtl/bpsk_iad_receiver.sv
// N-channel BPSK integrate-and-dump receiver.
// Each channel sums SPS signed samples per symbol and emits one decision:
// hard mode gives +1 / most-negative codes, soft mode gives the saturated sum.
// An output vector waiting for the sink stalls only the sample that would dump.
module bpsk_iad_receiver #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 16,
  parameter int SPS      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sync,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic [31:0]                  sym_count
);

  localparam int ACC_W = DATA_W + $clog2(SPS) + 1;
  localparam int PH_W  = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [PH_W:0] SPS_V = (PH_W+1)'(SPS);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] HARD_POS = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] HARD_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [PH_W-1:0]          phase;
  logic [PH_W:0]            phase_next;
  logic                     load;
  logic                     dump;
  logic                     accept;
  logic signed [ACC_W-1:0]  acc [CHANNELS];
  logic signed [ACC_W-1:0]  ext [CHANNELS];
  logic signed [ACC_W-1:0]  sum [CHANNELS];
  logic [CHANNELS*DATA_W-1:0] dec;

  // Symbol phase bookkeeping: a sync or a fresh symbol loads instead of adding.
  always_comb begin
    load       = (phase == '0) || in_sync;
    phase_next = load ? (PH_W+1)'(1) : ({1'b0, phase} + (PH_W+1)'(1));
    dump       = (phase_next == SPS_V);
  end

  // A pending, unconsumed output blocks only the sample that would overwrite it.
  assign in_ready = !(out_valid && !out_ready && dump);
  assign accept   = in_valid && in_ready;

  // Per-channel running sum and the decision it would produce if this sample dumps.
  always_comb begin
    dec = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ext[c] = {{(ACC_W-DATA_W){in_data[c*DATA_W+DATA_W-1]}}, in_data[c*DATA_W +: DATA_W]};
      sum[c] = load ? ext[c] : (acc[c] + ext[c]);
      if (mode) begin
        if (sum[c] > SAT_MAX)
          dec[c*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
        else if (sum[c] < SAT_MIN)
          dec[c*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
        else
          dec[c*DATA_W +: DATA_W] = sum[c][DATA_W-1:0];
      end else begin
        dec[c*DATA_W +: DATA_W] = sum[c][ACC_W-1] ? HARD_NEG : HARD_POS;
      end
    end
  end

  // Accumulators, phase, output register and consumed-symbol counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      for (int c = 0; c < CHANNELS; c++) acc[c] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sym_count <= '0;
    end else begin
      if (accept) begin
        phase <= dump ? '0 : phase_next[PH_W-1:0];
        for (int c = 0; c < CHANNELS; c++) acc[c] <= sum[c];
      end
      if (accept && dump) begin
        out_data  <= dec;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) sym_count <= sym_count + 32'd1;
    end
  end

endmodule
